tri_serializer: RTL and testbench

- Transmit side of the rasterizer's serial triangle input.
- Accepts whole triangles as parallel 144-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each triangle out MSB-first on a single serial line, exactly 144 bits per triangle, for the rasterizer's deserializer.
- Holds the next triangle until the rasterizer pulses its done-with-triangle output, so frames never overlap.

---
 rtl/tri_serializer.sv | 156 +++++++++++++++
 tb/tb_tri_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_serializer.sv
// tri_serializer: buffers parallel triangle words in a small FIFO and shifts each one
// out MSB-first on a single serial line. After each frame it waits for the rasterizer's
// done pulse before starting the next one.
// Optional build macro TRI_CULL_EN: drops zero-area triangles at pop time and counts
// them in CULL_CNT. Without the macro, CULL_CNT is tied to 0.
module tri_serializer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TRI_W = 144,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [TRI_W-1:0] TRI_IN,
    input  logic             TRI_VALID,
    output logic             TRI_READY,
    output logic             D,
    input  logic             RAST_DONE,
    output logic             BUSY,
    output logic [CNT_W-1:0] SENT_CNT,
    output logic [CNT_W-1:0] CULL_CNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [7:0]  LAST_BIT = 8'(TRI_W - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StWaitDone} state_t;

    state_t           state;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [TRI_W-1:0] mem [DEPTH];
    logic [TRI_W-1:0] head;
    logic [TRI_W-1:0] shreg;
    logic [7:0]       bit_cnt;
    logic             d_q;
    logic             busy_q;
    logic [CNT_W-1:0] sent_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             degenerate;

    // Pointer MSBs differ with equal low bits when full; equal pointers mean empty.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign TRI_READY = !full && !RST;
    assign push      = TRI_VALID && TRI_READY;
    assign pop       = (state == StIdle) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign D        = d_q;
    assign BUSY     = busy_q;
    assign SENT_CNT = sent_cnt;

`ifdef TRI_CULL_EN
    logic [CNT_W-1:0]  cull_cnt;
    logic signed [16:0] dx2, dy3, dx3, dy2;
    logic signed [33:0] prod_a, prod_b;
    logic signed [34:0] area;

    // Twice the signed triangle area from the FIFO head; zero means collinear.
    always_comb begin
        dx2        = $signed({head[95], head[95:80]}) - $signed({head[143], head[143:128]});
        dy3        = $signed({head[31], head[31:16]}) - $signed({head[127], head[127:112]});
        dx3        = $signed({head[47], head[47:32]}) - $signed({head[143], head[143:128]});
        dy2        = $signed({head[79], head[79:64]}) - $signed({head[127], head[127:112]});
        prod_a     = dx2 * dy3;
        prod_b     = dx3 * dy2;
        area       = $signed({prod_a[33], prod_a}) - $signed({prod_b[33], prod_b});
        degenerate = (area == '0);
    end

    assign CULL_CNT = cull_cnt;
`else
    assign degenerate = 1'b0;
    assign CULL_CNT   = '0;
`endif

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= TRI_IN;
        end
    end

    // FIFO pointers; a push and a pop in the same cycle both take effect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Frame FSM: pop, one settle cycle, 144 shifted bits, then hold until RAST_DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= StIdle;
            shreg    <= '0;
            bit_cnt  <= '0;
            d_q      <= 1'b0;
            busy_q   <= 1'b0;
            sent_cnt <= '0;
`ifdef TRI_CULL_EN
            cull_cnt <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    d_q <= 1'b0;
                    if (pop) begin
                        if (degenerate) begin
`ifdef TRI_CULL_EN
                            cull_cnt <= cull_cnt + CNT_W'(1);
`endif
                        end else begin
                            shreg  <= head;
                            state  <= StLoad;
                            busy_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    d_q     <= shreg[TRI_W-1];
                    shreg   <= {shreg[TRI_W-2:0], 1'b0};
                    bit_cnt <= '0;
                    state   <= StShift;
                end
                StShift: begin
                    if (bit_cnt == LAST_BIT) begin
                        d_q      <= 1'b0;
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        state    <= StWaitDone;
                    end else begin
                        d_q     <= shreg[TRI_W-1];
                        shreg   <= {shreg[TRI_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                StWaitDone: begin
                    d_q <= 1'b0;
                    if (RAST_DONE) begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_serializer.sv
// Directed bench for tri_serializer: table of frames plus hand sequences for queueing,
// ignored done pulses, mid-frame reset and (with TRI_CULL_EN) culling.
module tb_tri_serializer;

    logic         CLK = 1'b0;
    logic         RST;
    logic [143:0] TRI_IN;
    logic         TRI_VALID;
    logic         TRI_READY;
    logic         D;
    logic         RAST_DONE;
    logic         BUSY;
    logic [15:0]  SENT_CNT;
    logic [15:0]  CULL_CNT;

    tri_serializer #(.DEPTH(2), .TRI_W(144), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TRI_IN    (TRI_IN),
        .TRI_VALID (TRI_VALID),
        .TRI_READY (TRI_READY),
        .D         (D),
        .RAST_DONE (RAST_DONE),
        .BUSY      (BUSY),
        .SENT_CNT  (SENT_CNT),
        .CULL_CNT  (CULL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [143:0] word;
        logic [15:0]  exp_sent;
    } vec_t;

    vec_t         vecs [4];
    logic [143:0] sb [$];
    int           total = 0;
    int           bad = 0;
    int           exp_sent = 0;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns in the cycle right after the accepting edge.
    task automatic push(input logic [143:0] w);
        int n = 0;
        TRI_IN    = w;
        TRI_VALID = 1'b1;
        while (!TRI_READY && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL push_timeout: TRI_READY stayed %b, wanted 1", TRI_READY);
        end
        tick();
        TRI_VALID = 1'b0;
        sb.push_back(w);
    endtask

    // Called in the cycle that should show bit 143; ends in the first WAIT_DONE cycle.
    task automatic capture(input int done_at);
        logic [143:0] got;
        logic [143:0] exp;
        for (int i = 0; i < 144; i++) begin
            got[143-i] = D;
            if (i == done_at) RAST_DONE = 1'b1;
            tick();
            RAST_DONE = 1'b0;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 144'hx;
        chk("frame_bits", got, exp);
        chk("d_in_wait", {143'd0, D}, 144'd0);
        chk("busy_in_wait", {143'd0, BUSY}, 144'd1);
    endtask

    task automatic done_pulse();
        RAST_DONE = 1'b1;
        tick();
        RAST_DONE = 1'b0;
        chk("busy_after_done", {143'd0, BUSY}, 144'd0);
        chk("d_after_done", {143'd0, D}, 144'd0);
    endtask

    // From the IDLE cycle after a pop-eligible state, walk through LOAD to the first bit.
    task automatic to_first_bit();
        tick();
        chk("busy_load", {143'd0, BUSY}, 144'd1);
        chk("d_load", {143'd0, D}, 144'd0);
        tick();
    endtask

    logic [143:0] wa, wb, wc, wd;

    initial begin
        vecs[0] = '{144'h0140_0080_FFC0_0280_0080_0000_0140_0200_001F, 16'd1};
        vecs[1] = '{144'h8000_7FFF_1234_0001_FFFF_5678_4000_C000_9ABD, 16'd2};
        vecs[2] = '{144'h0001_0000_FFFF_0000_0001_AAAA_0002_0003_5555, 16'd3};
        vecs[3] = '{144'h0000_0000_0000_0280_0000_0000_0000_0280_0000, 16'd4};

        RST = 1'b1; TRI_IN = '0; TRI_VALID = 1'b0; RAST_DONE = 1'b0;
        #1;
        chk("rst_ready", {143'd0, TRI_READY}, 144'd0);
        chk("rst_d", {143'd0, D}, 144'd0);
        chk("rst_busy", {143'd0, BUSY}, 144'd0);
        chk("rst_sent", {128'd0, SENT_CNT}, 144'd0);
        chk("rst_cull", {128'd0, CULL_CNT}, 144'd0);
        repeat (3) tick();
        RST = 1'b0;
        #1;
        chk("ready_after_rst", {143'd0, TRI_READY}, 144'd1);

        // Single frames: exact latency, full bit stream, SENT_CNT per frame.
        for (int v = 0; v < 4; v++) begin
            push(vecs[v].word);
            chk("busy_idle", {143'd0, BUSY}, 144'd0);
            chk("d_idle", {143'd0, D}, 144'd0);
            to_first_bit();
            capture(-1);
            chk("sent_vec", {128'd0, SENT_CNT}, {128'd0, vecs[v].exp_sent});
            done_pulse();
        end
        exp_sent = 4;

        // Three pushes while done is withheld; a fourth waits on a full FIFO.
        wa = 144'hAAAA_0001_0002_0003_0004_0005_0006_0007_0008;
        wb = 144'hB00B_1111_2222_3333_4444_5555_6666_7777_8888;
        wc = 144'hC0C0_0F0F_F0F0_00FF_FF00_1357_2468_ACE0_BDF1;
        wd = 144'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654;
        push(wa);
        push(wb);
        push(wc);
        chk("full_ready_low", {143'd0, TRI_READY}, 144'd0);
        TRI_IN    = wd;
        TRI_VALID = 1'b1;
        capture(-1);
        exp_sent++;
        chk("sent_q1", {128'd0, SENT_CNT}, exp_sent[143:0]);
        chk("ready_still_full", {143'd0, TRI_READY}, 144'd0);
        RAST_DONE = 1'b1;
        tick();
        RAST_DONE = 1'b0;
        chk("no_push_on_pop_cycle", {143'd0, TRI_READY}, 144'd0);
        tick();
        chk("ready_after_pop", {143'd0, TRI_READY}, 144'd1);
        tick();
        TRI_VALID = 1'b0;
        sb.push_back(wd);
        chk("ready_full_again", {143'd0, TRI_READY}, 144'd0);
        capture(-1);
        exp_sent++;
        chk("sent_q2", {128'd0, SENT_CNT}, exp_sent[143:0]);
        done_pulse();
        to_first_bit();
        capture(-1);
        exp_sent++;
        chk("sent_q3", {128'd0, SENT_CNT}, exp_sent[143:0]);
        done_pulse();
        to_first_bit();
        capture(-1);
        exp_sent++;
        chk("sent_q4", {128'd0, SENT_CNT}, exp_sent[143:0]);
        done_pulse();

        // A done pulse during SHIFT is ignored; WAIT_DONE holds until a later pulse.
        push(144'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_6969_9696_1E1E);
        to_first_bit();
        capture(70);
        for (int k = 0; k < 5; k++) begin
            chk("wait_hold_d", {143'd0, D}, 144'd0);
            chk("wait_hold_busy", {143'd0, BUSY}, 144'd1);
            tick();
        end
        exp_sent++;
        chk("sent_after_ignored", {128'd0, SENT_CNT}, exp_sent[143:0]);
        done_pulse();

        // Reset in the middle of a frame, then a clean frame.
        push(144'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF);
        to_first_bit();
        repeat (100) tick();
        RST = 1'b1;
        #1;
        chk("midrst_d", {143'd0, D}, 144'd0);
        chk("midrst_busy", {143'd0, BUSY}, 144'd0);
        chk("midrst_sent", {128'd0, SENT_CNT}, 144'd0);
        chk("midrst_cull", {128'd0, CULL_CNT}, 144'd0);
        chk("midrst_ready", {143'd0, TRI_READY}, 144'd0);
        sb.delete();
        exp_sent = 0;
        tick();
        RST = 1'b0;
        #1;
        chk("postrst_ready", {143'd0, TRI_READY}, 144'd1);
        repeat (3) tick();
        chk("postrst_empty_idle", {143'd0, BUSY}, 144'd0);
        push(144'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_8001);
        to_first_bit();
        capture(-1);
        chk("sent_postrst", {128'd0, SENT_CNT}, 144'd1);
        done_pulse();

`ifdef TRI_CULL_EN
        // Collinear triangle is dropped; a real triangle still goes out.
        push(144'h0000_0000_0000_0040_0040_0000_0080_0080_0000);
        void'(sb.pop_back());
        for (int k = 0; k < 4; k++) begin
            chk("cull_d", {143'd0, D}, 144'd0);
            chk("cull_busy", {143'd0, BUSY}, 144'd0);
            tick();
        end
        chk("cull_cnt", {128'd0, CULL_CNT}, 144'd1);
        chk("cull_sent", {128'd0, SENT_CNT}, 144'd1);
        push(vecs[3].word);
        to_first_bit();
        capture(-1);
        chk("cull_sent_after", {128'd0, SENT_CNT}, 144'd2);
        done_pulse();
`else
        chk("cull_zero", {128'd0, CULL_CNT}, 144'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
